// File: rtl/nvdla_qch_pkg.sv
// Shared state encoding and output decode helpers for the NVDLA Q-Channel initiator.
package nvdla_qch_pkg;

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    REQUEST = 3'd1,
    STOPPED = 3'd2,
    EXIT    = 3'd3,
    DENIED  = 3'd4
  } q_state_e;

  // qreqn is active-low: it is high only in states that are not asking for quiescence
  function automatic logic qreqn_for(input q_state_e s);
    return (s == RUN) || (s == EXIT) || (s == DENIED);
  endfunction

  function automatic logic clk_en_for(input q_state_e s);
    return s != STOPPED;
  endfunction

endpackage

// File: rtl/nvdla_qch_idle_cnt.sv
// Saturating up-counter with synchronous clear and a compare-to-threshold flag.
module nvdla_qch_idle_cnt
  import nvdla_qch_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         nvdla_core_clk,
  input  logic         nvdla_core_rstn,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] thresh,
  output logic         hit
);

  logic [W-1:0] cnt;

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign hit = (cnt >= thresh);

endmodule

// File: rtl/nvdla_qchannel_ctrl.sv
// Q-Channel initiator: requests device quiescence on idle/force, wakes on activity,
// drives the device clock-gate enable and flags handshake protocol violations.
module nvdla_qchannel_ctrl
  import nvdla_qch_pkg::*;
#(
  parameter int unsigned IDLE_W  = 16,
  parameter int unsigned BACKOFF = 8,
  parameter int unsigned DENY_W  = 8
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rstn,
  input  logic              activity,
  input  logic              wake_req,
  input  logic              sleep_en,
  input  logic              force_stop,
  input  logic [IDLE_W-1:0] idle_thresh,
  output logic              qreqn,
  input  logic              qacceptn,
  input  logic              qdeny,
  output logic              clk_en,
  output logic [2:0]        q_state,
  output logic [DENY_W-1:0] deny_cnt,
  output logic              proto_err
);

  localparam int unsigned BO_W = (BACKOFF > 1) ? $clog2(BACKOFF) : 1;
  localparam logic [BO_W-1:0] BO_THRESH = BO_W'(BACKOFF - 1);

  q_state_e state;
  q_state_e nxt;
  logic     idle_inc, idle_clr, idle_hit;
  logic     bo_inc, bo_clr, bo_hit;
  logic     sleep_due, proto_viol;

  always_comb begin
    idle_inc = (state == RUN) && sleep_en && !activity;
    idle_clr = !idle_inc;
    bo_inc   = (state == DENIED) && !qdeny;
    bo_clr   = !bo_inc;
  end

  nvdla_qch_idle_cnt #(.W(IDLE_W)) u_idle_cnt (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .clr             (idle_clr),
    .inc             (idle_inc),
    .thresh          (idle_thresh),
    .hit             (idle_hit)
  );

  // Backoff reuses the idle counter; BACKOFF-1 threshold gives RUN on the BACKOFF-th quiet edge
  nvdla_qch_idle_cnt #(.W(BO_W)) u_backoff_cnt (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .clr             (bo_clr),
    .inc             (bo_inc),
    .thresh          (BO_THRESH),
    .hit             (bo_hit)
  );

  always_comb begin
    sleep_due = force_stop || (sleep_en && (idle_thresh != '0) && idle_hit);
    nxt = state;
    case (state)
      RUN:     if (!wake_req && !activity && sleep_due) nxt = REQUEST;
      REQUEST: begin
        if (!qacceptn)  nxt = STOPPED;
        else if (qdeny) nxt = DENIED;
      end
      STOPPED: if (wake_req || activity) nxt = EXIT;
      EXIT:    if (qacceptn) nxt = RUN;
      DENIED:  if (!qdeny && bo_hit) nxt = RUN;
      default: nxt = STOPPED;
    endcase
  end

  always_comb begin
    proto_viol = ((state == RUN) && !qacceptn)
              || (((state == RUN) || (state == STOPPED)) && qdeny)
              || ((state == STOPPED) && qacceptn)
              || ((state == REQUEST) && !qacceptn && qdeny);
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      state     <= STOPPED;
      qreqn     <= 1'b0;
      clk_en    <= 1'b1;
      deny_cnt  <= '0;
      proto_err <= 1'b0;
    end else begin
      state  <= nxt;
      qreqn  <= qreqn_for(nxt);
      clk_en <= clk_en_for(nxt);
      if ((state == REQUEST) && qacceptn && qdeny && (deny_cnt != '1)) begin
        deny_cnt <= deny_cnt + DENY_W'(1);
      end
      if (proto_viol) begin
        proto_err <= 1'b1;
      end
    end
  end

  assign q_state = state;

endmodule

// File: tb/tb_nvdla_qchannel_ctrl.sv
// Scoreboard bench for nvdla_qchannel_ctrl: stimulus queues expected output changes,
// a monitor pops one entry on every change of the registered outputs.
module tb_nvdla_qchannel_ctrl;
  import nvdla_qch_pkg::*;

  localparam int unsigned IDLE_W  = 4;
  localparam int unsigned BACKOFF = 8;
  localparam int unsigned DENY_W  = 8;

  logic              nvdla_core_clk = 1'b0;
  logic              nvdla_core_rstn;
  logic              activity, wake_req, sleep_en, force_stop;
  logic [IDLE_W-1:0] idle_thresh;
  logic              qreqn, qacceptn, qdeny, clk_en, proto_err;
  logic [2:0]        q_state;
  logic [DENY_W-1:0] deny_cnt;

  nvdla_qchannel_ctrl #(.IDLE_W(IDLE_W), .BACKOFF(BACKOFF), .DENY_W(DENY_W)) dut (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .activity        (activity),
    .wake_req        (wake_req),
    .sleep_en        (sleep_en),
    .force_stop      (force_stop),
    .idle_thresh     (idle_thresh),
    .qreqn           (qreqn),
    .qacceptn        (qacceptn),
    .qdeny           (qdeny),
    .clk_en          (clk_en),
    .q_state         (q_state),
    .deny_cnt        (deny_cnt),
    .proto_err       (proto_err)
  );

  always #5 nvdla_core_clk = ~nvdla_core_clk;

  typedef struct {
    string             tag;
    logic [2:0]        st;
    logic              rq;
    logic              ce;
    logic [DENY_W-1:0] dn;
    logic              pe;
    int                at;
  } exp_t;

  exp_t sb[$];
  int   ncyc   = 0;
  int   checks = 0;
  int   fails  = 0;

  task automatic expect_out(input string tag, input q_state_e st, input logic rq,
                            input logic ce, input int dn, input logic pe, input int at);
    exp_t e;
    e.tag = tag;
    e.st  = st;
    e.rq  = rq;
    e.ce  = ce;
    e.dn  = (dn > 255) ? 8'd255 : DENY_W'(dn);
    e.pe  = pe;
    e.at  = at;
    sb.push_back(e);
  endtask

  task automatic wait_to(input int n);
    while (ncyc < n) @(negedge nvdla_core_clk);
  endtask

  // Monitor: ncyc holds the index of the posedge just taken
  logic [13:0] prev_vec;
  bit          first = 1'b1;
  always @(posedge nvdla_core_clk) begin
    logic [13:0] cur, want;
    exp_t        e;
    #1;
    ncyc++;
    cur = {q_state, qreqn, clk_en, deny_cnt, proto_err};
    if (first || (cur != prev_vec)) begin
      first = 1'b0;
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_change cycle %0d: got state=%0d qreqn=%b clk_en=%b deny=%0d perr=%b, required no change",
                 ncyc, q_state, qreqn, clk_en, deny_cnt, proto_err);
      end else begin
        e    = sb.pop_front();
        want = {e.st, e.rq, e.ce, e.dn, e.pe};
        if (cur !== want) begin
          fails++;
          $display("FAIL %s cycle %0d: got state=%0d qreqn=%b clk_en=%b deny=%0d perr=%b, required state=%0d qreqn=%b clk_en=%b deny=%0d perr=%b",
                   e.tag, ncyc, q_state, qreqn, clk_en, deny_cnt, proto_err, e.st, e.rq, e.ce, e.dn, e.pe);
        end
        checks++;
        if (ncyc != e.at) begin
          fails++;
          $display("FAIL %s_timing: got cycle %0d, required cycle %0d", e.tag, ncyc, e.at);
        end
      end
      prev_vec = cur;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within the cycle budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r, rr;
    nvdla_core_rstn = 1'b0;
    activity = 1'b0; wake_req = 1'b0; sleep_en = 1'b0; force_stop = 1'b0;
    idle_thresh = '0; qacceptn = 1'b0; qdeny = 1'b0;

    // Reset, then clk_en drops one cycle after release
    expect_out("reset",          STOPPED, 1'b0, 1'b1, 0, 1'b0, 1);
    expect_out("clk_en_fall",    STOPPED, 1'b0, 1'b0, 0, 1'b0, 3);
    wait_to(2); nvdla_core_rstn = 1'b1;

    // Auto sleep/wake
    expect_out("wake_exit",      EXIT,    1'b1, 1'b1, 0, 1'b0, 4);
    expect_out("wake_run",       RUN,     1'b1, 1'b1, 0, 1'b0, 5);
    expect_out("idle_request",   REQUEST, 1'b0, 1'b1, 0, 1'b0, 10);
    expect_out("accept_stop",    STOPPED, 1'b0, 1'b0, 0, 1'b0, 28);
    wait_to(3); wake_req = 1'b1;
    wait_to(4); wake_req = 1'b0; qacceptn = 1'b1; sleep_en = 1'b1; idle_thresh = 4'd4;
    wait_to(27); qacceptn = 1'b0;

    // Wake from STOPPED on activity
    expect_out("act_exit",       EXIT,    1'b1, 1'b1, 0, 1'b0, 31);
    expect_out("act_run",        RUN,     1'b1, 1'b1, 0, 1'b0, 33);
    wait_to(30); activity = 1'b1; sleep_en = 1'b0;
    wait_to(31); activity = 1'b0;
    wait_to(32); qacceptn = 1'b1;

    // Toggling activity keeps the idle counter below 3: no output change
    wait_to(33); sleep_en = 1'b1; idle_thresh = 4'd3;
    for (int k = 0; k < 20; k++) begin
      wait_to(33 + k);
      activity = ((k / 2) % 2) != 0;
    end

    // force_stop with wake_req: wake wins; then force alone, deny, backoff, re-request
    expect_out("force_request",  REQUEST, 1'b0, 1'b1, 0, 1'b0, 57);
    expect_out("deny_1",         DENIED,  1'b1, 1'b1, 1, 1'b0, 58);
    expect_out("backoff_run",    RUN,     1'b1, 1'b1, 1, 1'b0, 68);
    expect_out("re_request",     REQUEST, 1'b0, 1'b1, 1, 1'b0, 69);
    wait_to(53); activity = 1'b0; sleep_en = 1'b0; force_stop = 1'b1; wake_req = 1'b1;
    wait_to(56); wake_req = 1'b0;
    wait_to(57); qdeny = 1'b1;
    wait_to(60); qdeny = 1'b0;

    // 299 further denies: deny_cnt saturates at 255
    r = 69;
    for (int i = 0; i < 299; i++) begin
      expect_out("deny_loop",     DENIED,  1'b1, 1'b1, 2 + i, 1'b0, r + 1);
      expect_out("deny_loop_run", RUN,     1'b1, 1'b1, 2 + i, 1'b0, r + 9);
      if (i < 298)
        expect_out("deny_loop_req", REQUEST, 1'b0, 1'b1, 2 + i, 1'b0, r + 10);
      wait_to(r); qdeny = 1'b1;
      wait_to(r + 1); qdeny = 1'b0;
      if (i == 298) force_stop = 1'b0;
      r = r + 10;
    end
    rr = r - 1;

    // Accept and deny together: accept wins, proto_err is sticky
    expect_out("perr_request",   REQUEST, 1'b0, 1'b1, 255, 1'b0, rr + 2);
    expect_out("perr_stop",      STOPPED, 1'b0, 1'b0, 255, 1'b1, rr + 3);
    expect_out("perr_exit",      EXIT,    1'b1, 1'b1, 255, 1'b1, rr + 6);
    expect_out("perr_run",       RUN,     1'b1, 1'b1, 255, 1'b1, rr + 7);
    expect_out("perr_req2",      REQUEST, 1'b0, 1'b1, 255, 1'b1, rr + 8);
    wait_to(rr + 1); force_stop = 1'b1;
    wait_to(rr + 2); force_stop = 1'b0; qacceptn = 1'b0; qdeny = 1'b1;
    wait_to(rr + 3); qdeny = 1'b0;
    wait_to(rr + 5); activity = 1'b1;
    wait_to(rr + 6); activity = 1'b0; qacceptn = 1'b1;
    wait_to(rr + 7); force_stop = 1'b1;

    // Reset in REQUEST, then reset release with wake_req held
    expect_out("rst_in_request", STOPPED, 1'b0, 1'b1, 0, 1'b0, rr + 9);
    expect_out("rst_clk_en",     STOPPED, 1'b0, 1'b0, 0, 1'b0, rr + 10);
    expect_out("rst_wake",       STOPPED, 1'b0, 1'b1, 0, 1'b0, rr + 13);
    expect_out("rst_wake_exit",  EXIT,    1'b1, 1'b1, 0, 1'b0, rr + 14);
    expect_out("rst_wake_run",   RUN,     1'b1, 1'b1, 0, 1'b0, rr + 15);
    wait_to(rr + 8); force_stop = 1'b0; nvdla_core_rstn = 1'b0; qacceptn = 1'b0;
    wait_to(rr + 9); nvdla_core_rstn = 1'b1;
    wait_to(rr + 12); nvdla_core_rstn = 1'b0; wake_req = 1'b1;
    wait_to(rr + 13); nvdla_core_rstn = 1'b1;
    wait_to(rr + 14); wake_req = 1'b0; qacceptn = 1'b1;

    // All-ones threshold with wake_req blocking entry: counter must saturate, not wrap
    expect_out("sat_request",    REQUEST, 1'b0, 1'b1, 0, 1'b0, rr + 41);
    expect_out("sat_stop",       STOPPED, 1'b0, 1'b0, 0, 1'b0, rr + 42);
    wait_to(rr + 15); sleep_en = 1'b1; idle_thresh = 4'hF; wake_req = 1'b1;
    wait_to(rr + 40); wake_req = 1'b0;
    wait_to(rr + 41); qacceptn = 1'b0;

    wait_to(rr + 46);
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending entries, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
